// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and transmit-scheduler state encodings.
package uart_pkg;

    typedef enum logic [1:0] {
        ParNone = 2'd0,
        ParOdd  = 2'd1,
        ParEven = 2'd2
    } parity_e;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLoad     = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } sched_state_e;

    // Request code 3 has no meaning on the line and is sent as no parity.
    function automatic parity_e sanitize_parity(input logic [1:0] mode);
        return (mode == 2'd3) ? ParNone : parity_e'(mode);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter; the search starts one past the last grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((32'(last_grant) + off) % NUM_REQ);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                id       = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned START_TIMEOUT = 1024,
    parameter int unsigned ID_W          = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]         req_parity,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic [1:0]                   tx_parity_type,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [ID_W-1:0]              grant_id,
    output logic                         done_valid,
    output logic                         timeout_err
);

    localparam int unsigned CNT_W = $clog2(START_TIMEOUT) + 1;

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_seen_q;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic               done_hit, timeout_hit;
    logic [NUM_REQ-1:0] req_ready_d;
    logic               tx_start_d, done_valid_d, timeout_err_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .id         (arb_id),
        .any        (arb_any)
    );

    // A done seen during the load cycle still counts as completion in WAIT_BUSY.
    assign done_hit    = tx_done | done_seen_q;
    // cnt_q is 0 in the load cycle, so this fires START_TIMEOUT-1 cycles after tx_start.
    assign timeout_hit = (cnt_q == CNT_W'(START_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (arb_any) state_d = StLoad;
            StLoad:     state_d = StWaitBusy;
            StWaitBusy: begin
                if (done_hit)         state_d = StIdle;
                else if (tx_busy)     state_d = StWaitDone;
                else if (timeout_hit) state_d = StIdle;
            end
            StWaitDone: if (tx_done) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        done_valid_d  = 1'b0;
        timeout_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    req_ready_d = arb_gnt;
                    tx_start_d  = 1'b1;
                end
            end
            StWaitBusy: begin
                done_valid_d  = done_hit;
                timeout_err_d = !done_hit && !tx_busy && timeout_hit;
            end
            StWaitDone: done_valid_d = tx_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready      <= '0;
            tx_start       <= 1'b0;
            done_valid     <= 1'b0;
            timeout_err    <= 1'b0;
            tx_data        <= '0;
            tx_parity_type <= ParNone;
            grant_id       <= '0;
            last_grant_q   <= ID_W'(NUM_REQ - 1);
            cnt_q          <= '0;
            done_seen_q    <= 1'b0;
        end else begin
            req_ready   <= req_ready_d;
            tx_start    <= tx_start_d;
            done_valid  <= done_valid_d;
            timeout_err <= timeout_err_d;
            if (state_q == StIdle && arb_any) begin
                tx_data        <= req_data[arb_id*DATA_BITS +: DATA_BITS];
                tx_parity_type <= sanitize_parity(req_parity[arb_id*2 +: 2]);
                grant_id       <= arb_id;
                cnt_q          <= '0;
                done_seen_q    <= 1'b0;
            end else if (state_q == StLoad || state_q == StWaitBusy) begin
                cnt_q       <= cnt_q + CNT_W'(1);
                done_seen_q <= done_seen_q | tx_done;
            end
            if (state_q == StLoad) begin
                last_grant_q <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised and directed bench for uart_tx_scheduler against a timestamp-based reference model.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DB-1:0] req_data = '0;
    logic [N*2-1:0]  req_parity = '0;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DB-1:0]   tx_data;
    logic [1:0]      tx_parity_type;
    logic            tx_busy = 1'b0;
    logic            tx_done = 1'b0;
    logic [IW-1:0]   grant_id;
    logic            done_valid;
    logic            timeout_err;

    uart_tx_scheduler #(
        .NUM_REQ       (N),
        .DATA_BITS     (DB),
        .START_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_parity     (req_parity),
        .req_ready      (req_ready),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_parity_type (tx_parity_type),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .grant_id       (grant_id),
        .done_valid     (done_valid),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: an outstanding frame is described by its start cycle and what was seen.
    bit           m_out, m_busy, m_early;
    int           m_last, m_start;
    logic [N-1:0] e_ready;
    logic         e_start, e_done, e_to;
    logic [DB-1:0] e_data;
    logic [1:0]   e_par;
    int           e_gid;

    int stub_mode = 0;
    int busy_from = -1, busy_to = -1, done_at = -1;
    bit auto_req = 0;
    bit chk_en = 0;

    logic [N-1:0] ready_obs = '0;
    logic         start_obs = 1'b0;
    int grants[$];
    int last_start_c = -1, last_done_c = -1, last_to_c = -1, last_txdone_c = -1;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_out = 0; m_busy = 0; m_early = 0; m_last = N - 1; m_start = 0;
        e_ready = '0; e_start = 0; e_done = 0; e_to = 0;
        e_data = '0; e_par = '0; e_gid = 0;
    endtask

    task automatic finish_frame(input bit ok);
        if (ok) e_done = 1'b1;
        else    e_to   = 1'b1;
        m_out = 0;
    endtask

    // Called at the edge that ends cycle cyc; sets expectations for cycle cyc+1.
    task automatic model_step();
        int c = cyc;
        e_ready = '0; e_start = 0; e_done = 0; e_to = 0;
        if (!m_out) begin
            if (req_valid != '0) begin
                int w = pick();
                e_ready = '0;
                e_ready[w] = 1'b1;
                e_start = 1'b1;
                e_data  = req_data[w*DB +: DB];
                e_par   = req_parity[w*2 +: 2];
                if (e_par == 2'd3) e_par = 2'd0;
                e_gid   = w;
                m_last  = w;
                m_out   = 1; m_start = c + 1; m_busy = 0; m_early = 0;
            end
        end else if (c == m_start) begin
            if (tx_done) m_early = 1;
        end else if (!m_busy) begin
            if (tx_done || m_early)     finish_frame(1);
            else if (tx_busy)           m_busy = 1;
            else if (c + 1 == m_start + TO) finish_frame(0);
        end else if (tx_done) begin
            finish_frame(1);
        end
    endtask

    // Transmitter stub: reacts to a tx_start seen in the previous cycle.
    task automatic drive_stub();
        int m, d;
        if (start_obs) begin
            m = (stub_mode >= 0) ? stub_mode :
                (($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3)));
            d = int'($urandom_range(0, 3));
            busy_from = -1; busy_to = -1; done_at = -1;
            case (m)
                0: begin
                    busy_from = cyc + d;
                    busy_to   = busy_from + int'($urandom_range(0, 3));
                    done_at   = busy_to + 1;
                end
                2: begin busy_from = cyc + d; busy_to = busy_from; done_at = busy_from; end
                3: done_at = cyc + d;
                4: begin busy_from = cyc; busy_to = cyc + 5; done_at = cyc + 6; end
                default: ;
            endcase
        end
        tx_busy = (cyc >= busy_from && cyc <= busy_to);
        tx_done = (cyc == done_at);
        if (tx_done) last_txdone_c = cyc;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (ready_obs[i]) begin
                req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*DB +: DB]  = DB'($urandom);
                    req_parity[i*2 +: 2]  = 2'($urandom);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        cyc++;
        #1;
        drive_stub();
        if (auto_req) drive_reqs();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        busy_from = -1; busy_to = -1; done_at = -1;
        tx_busy = 1'b0; tx_done = 1'b0;
        model_reset();
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_parity_type", tx_parity_type, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input int what, input int limit, input string name);
        bit hit = 0;
        for (int k = 0; k < limit && !hit; k++) begin
            cycle();
            case (what)
                0: hit = (last_start_c == cyc);
                1: hit = (last_done_c == cyc);
                2: hit = (last_to_c == cyc);
                default: hit = (last_done_c == cyc) || (last_to_c == cyc);
            endcase
        end
        check(name, 32'(hit), 1);
    endtask

    // Compare process: every cycle against the model, plus event bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            ready_obs = req_ready;
            start_obs = tx_start;
            if (chk_en) begin
                check("req_ready", req_ready, e_ready);
                check("tx_start", tx_start, e_start);
                check("tx_data", tx_data, e_data);
                check("tx_parity_type", tx_parity_type, e_par);
                check("grant_id", grant_id, e_gid);
                check("done_valid", done_valid, e_done);
                check("timeout_err", timeout_err, e_to);
            end
            if (tx_start) begin
                last_start_c = cyc;
                grants.push_back(int'(grant_id));
            end
            if (done_valid) begin
                last_done_c = cyc;
                done_cnt++;
            end
            if (timeout_err) last_to_c = cyc;
        end
    end

    initial begin
        int s, dc;
        model_reset();
        chk_en = 1;
        #2;
        do_reset();

        // Single requester 2, 0xA5, even parity.
        stub_mode = 0;
        req_valid = 4'b0100;
        req_data[2*DB +: DB] = 8'hA5;
        req_parity[5:4] = 2'd2;
        wait_for(0, 10, "a_start");
        check("a_tx_data", tx_data, 32'hA5);
        check("a_parity", tx_parity_type, 2);
        check("a_req_ready", req_ready, 4'b0100);
        req_valid = '0;
        wait_for(1, 30, "a_done");
        check("a_done_gid", grant_id, 2);
        check("a_done_lat", 32'(last_done_c - last_txdone_c), 1);

        // All four valid continuously: order 0,1,2,3,0.
        do_reset();
        grants.delete();
        req_valid = '1;
        for (int k = 0; k < 300 && grants.size() < 5; k++) cycle();
        check("b_grant_count", 32'(grants.size() >= 5), 1);
        if (grants.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("b_grant_order", 32'(grants[k]), 32'(k % 4));
        end

        // Parity code 3 goes out as none.
        do_reset();
        req_valid = 4'b0010;
        req_data[1*DB +: DB] = 8'h3C;
        req_parity[3:2] = 2'd3;
        wait_for(0, 10, "c_start");
        check("c_parity", tx_parity_type, 0);
        check("c_gid", grant_id, 1);
        req_valid = '0;
        wait_for(3, 40, "c_end");

        // Start timeout, then the next requester is served.
        do_reset();
        stub_mode = 1;
        req_valid = 4'b0011;
        wait_for(0, 10, "d_start");
        s = last_start_c;
        req_valid[0] = 1'b0;
        wait_for(2, 40, "d_timeout");
        check("d_timeout_lat", 32'(last_to_c - s), TO);
        check("d_no_done", 32'(last_done_c < s), 1);
        stub_mode = 0;
        wait_for(0, 10, "d_next_start");
        check("d_next_gid", grant_id, 1);
        req_valid = '0;
        wait_for(1, 30, "d_next_done");

        // Reset during WAIT_DONE with requester 3 pending.
        do_reset();
        stub_mode = 4;
        req_valid = 4'b1001;
        wait_for(0, 10, "e_start");
        repeat (3) cycle();
        do_reset();
        wait_for(0, 10, "e_restart");
        check("e_gid_others", grant_id, 0);
        req_valid = 4'b1000;
        repeat (3) cycle();
        do_reset();
        wait_for(0, 10, "e_restart_sole");
        check("e_gid_sole", grant_id, 3);
        req_valid = '0;
        wait_for(1, 30, "e_done");

        // tx_done together with tx_busy: one completion, no timeout.
        do_reset();
        stub_mode = 2;
        req_valid = 4'b0100;
        wait_for(0, 10, "f_start");
        s = last_start_c;
        dc = done_cnt;
        req_valid = '0;
        wait_for(1, 30, "f_done");
        repeat (TO + 4) cycle();
        check("f_single_done", 32'(done_cnt - dc), 1);
        check("f_no_timeout", 32'(last_to_c < s), 1);

        // Randomised traffic.
        do_reset();
        stub_mode = -1;
        auto_req = 1;
        repeat (3000) cycle();
        auto_req = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
